burst_memory: RTL and testbench
===============================

BURST_MEMORY -- requirements
Module: burst_memory

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning data word width in bits (a multiple of 8).
REQ-002 The block SHALL have parameter ADDR_W, default 7, meaning word-address width; depth is DEPTH = 2**ADDR_W words.
REQ-003 The block SHALL have parameter WAIT_STATES, default 1, meaning the idle cycles between request and first beat (0..15).
REQ-004 The block SHALL have port CLK, input, 1 bit, meaning the clock; all state changes occur on the falling edge of CLK.
REQ-005 The block SHALL have port RST, input, 1 bit, meaning synchronous active-high reset, sampled on the falling edge of CLK.
REQ-006 The block SHALL have port CS, input, 1 bit, meaning a request strobe.
REQ-007 The block SHALL have port WE, input, 1 bit, meaning write (1) or read (0), sampled with CS.
REQ-008 The block SHALL have port ADDR, input, ADDR_W bits, meaning the burst start word address.
REQ-009 The block SHALL have port LEN, input, 3 bits, meaning burst length minus 1 (1..8 beats).
REQ-010 The block SHALL have port BE, input, DATA_W/8 bits, meaning per-beat byte write enables.
REQ-011 The block SHALL have port Mem_Bus, inout, DATA_W bits, meaning the shared data bus.
REQ-012 The block SHALL have port READY, output, 1 bit, meaning the current cycle is a data beat.
REQ-013 The block SHALL have port BUSY, output, 1 bit, meaning the block is not in IDLE.

Function
REQ-014 The block SHALL implement the states IDLE, WAIT, XFER and INIT (INIT exists only with the macro in REQ-027).
REQ-015 In IDLE, an edge with CS=1 SHALL latch ADDR into cur_addr, WE into we_q and LEN into beat_cnt, then move to WAIT, or directly to XFER when WAIT_STATES=0.
REQ-016 WAIT SHALL last exactly WAIT_STATES cycles, counted by a down-counter, then move to XFER.
REQ-017 READY SHALL be 1 only in XFER; each XFER cycle is one beat, completed at the next falling edge.
REQ-018 On a write-beat edge, each byte i with BE[i]=1 SHALL be written from Mem_Bus into RAM[cur_addr], and bytes with BE[i]=0 SHALL be left unchanged.
REQ-019 During a read beat, Mem_Bus SHALL carry a data_out register loaded with RAM[cur_addr] on the edge entering that beat; read-beat latency is WAIT_STATES+1 cycles from the request edge.
REQ-020 Mem_Bus SHALL be high-impedance except in XFER with we_q=0.
REQ-021 After each beat, cur_addr SHALL increment modulo DEPTH (DEPTH-1 wraps to 0) and beat_cnt SHALL decrement; the beat with beat_cnt=0 SHALL be the last, after which the state returns to IDLE.
REQ-022 CS, WE, ADDR and LEN SHALL be ignored outside IDLE; CS held at 1 in IDLE after a burst SHALL start a new burst on the next edge.
REQ-023 BUSY SHALL be 1 in WAIT, XFER and INIT, and 0 in IDLE.

Reset
REQ-024 On an edge with RST=1, the state SHALL become IDLE (or INIT per REQ-027), and READY, BUSY (IDLE case), the counters, we_q and data_out SHALL be cleared to 0.
REQ-025 RST SHALL take priority over every other input; a beat coincident with RST SHALL NOT write RAM, and a burst in progress SHALL be aborted.
REQ-026 RAM contents SHALL NOT be altered by reset unless REQ-027 applies.

Configuration
REQ-027 With MEM_INIT_CLEAR_EN defined, reset SHALL enter INIT, which writes 0 to one word per cycle from address 0 to DEPTH-1 (DEPTH cycles) with BUSY=1 and requests ignored, then moves to IDLE; without the macro, INIT SHALL NOT exist, reset SHALL go straight to IDLE, and RAM SHALL be uninitialised.

Verification
REQ-028 Write at ADDR=5, LEN=0, BE=4'hF, bus 32'hDEADBEEF, then read ADDR=5 -> READY one cycle, 2 edges after the request (WAIT_STATES=1), and bus = 32'hDEADBEEF.
REQ-029 Write at ADDR=126, LEN=3, data 1,2,3,4, then read 4 beats from ADDR=126 -> the words at addresses 126, 127, 0, 1 read back 1, 2, 3, 4 (wrap-around).
REQ-030 Write 32'hFFFFFFFF, then write 32'h00000000 with BE=4'b0101, then read -> 32'hFF00FF00.
REQ-031 Assert RST during beat 2 of a 4-beat write -> the next edge leaves BUSY=0 and READY=0, beats 2 and 3 are not written, and the bus is Z.
REQ-032 Hold CS=1 continuously -> back-to-back bursts with exactly one IDLE cycle between them, and mid-burst CS changes have no effect.
REQ-033 With MEM_INIT_CLEAR_EN defined and DEPTH=128, after RST -> BUSY=1 for 128 cycles and all words read 0; with the macro undefined -> BUSY=0 on the cycle after RST.

Source files
------------

// File: rtl/burst_memory.sv
// Burst-capable single-port word memory on a shared tri-state data bus.
// A request in IDLE latches address, direction and length, waits WAIT_STATES
// cycles, then performs 1..8 beats with incrementing (wrapping) word address.
// All state changes on the falling edge of CLK; RST is synchronous, active high.
// Optional macro MEM_INIT_CLEAR_EN: reset enters INIT and zeroes the whole RAM.
module burst_memory #(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned ADDR_W      = 7,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                CS,
    input  logic                WE,
    input  logic [ADDR_W-1:0]   ADDR,
    input  logic [2:0]          LEN,
    input  logic [DATA_W/8-1:0] BE,
    inout  wire  [DATA_W-1:0]   Mem_Bus,
    output logic                READY,
    output logic                BUSY
);

    localparam int unsigned NumBytes = DATA_W / 8;
    localparam int unsigned Depth    = 2 ** ADDR_W;
    // WAIT is entered with the counter preloaded so it lasts exactly WAIT_STATES cycles
    localparam logic [3:0]  WaitLoad = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);
`ifdef MEM_INIT_CLEAR_EN
    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(Depth - 1);
`endif

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWait = 2'd1,
        StXfer = 2'd2
`ifdef MEM_INIT_CLEAR_EN
        , StInit = 2'd3
`endif
    } state_e;

    logic [DATA_W-1:0] ram [Depth];

    state_e            state_q;
    logic [ADDR_W-1:0] cur_addr;
    logic [ADDR_W-1:0] next_addr;
    logic              we_q;
    logic [2:0]        beat_cnt;
    logic [3:0]        wait_cnt;
    logic [DATA_W-1:0] data_out;
    logic              ready_q;
    logic              busy_q;
`ifdef MEM_INIT_CLEAR_EN
    logic [ADDR_W-1:0] init_addr;
`endif

    // Address arithmetic wraps naturally at DEPTH-1 -> 0
    assign next_addr = cur_addr + ADDR_W'(1);

    assign READY = ready_q;
    assign BUSY  = busy_q;

    // Drive the bus only while a read beat is in progress
    assign Mem_Bus = (state_q == StXfer && !we_q) ? data_out : {DATA_W{1'bz}};

    // Control FSM with registered READY/BUSY and read data register
    always_ff @(negedge CLK) begin
        if (RST) begin
`ifdef MEM_INIT_CLEAR_EN
            state_q   <= StInit;
            busy_q    <= 1'b1;
            init_addr <= '0;
`else
            state_q   <= StIdle;
            busy_q    <= 1'b0;
`endif
            ready_q   <= 1'b0;
            cur_addr  <= '0;
            we_q      <= 1'b0;
            beat_cnt  <= 3'd0;
            wait_cnt  <= 4'd0;
            data_out  <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (CS) begin
                        cur_addr <= ADDR;
                        we_q     <= WE;
                        beat_cnt <= LEN;
                        busy_q   <= 1'b1;
                        if (WAIT_STATES == 0) begin
                            state_q  <= StXfer;
                            ready_q  <= 1'b1;
                            data_out <= ram[ADDR];
                        end else begin
                            state_q  <= StWait;
                            wait_cnt <= WaitLoad;
                        end
                    end
                end
                StWait: begin
                    if (wait_cnt == 4'd0) begin
                        state_q  <= StXfer;
                        ready_q  <= 1'b1;
                        data_out <= ram[cur_addr];
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                StXfer: begin
                    cur_addr <= next_addr;
                    if (beat_cnt == 3'd0) begin
                        state_q <= StIdle;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b0;
                    end else begin
                        beat_cnt <= beat_cnt - 3'd1;
                        // Prefetch the next word so it is on the bus for the next beat
                        data_out <= ram[next_addr];
                    end
                end
`ifdef MEM_INIT_CLEAR_EN
                StInit: begin
                    if (init_addr == LastAddr) begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end else begin
                        init_addr <= init_addr + ADDR_W'(1);
                    end
                end
`endif
                default: begin
                    state_q <= StIdle;
                    ready_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // RAM write port: byte-masked write beats, or clearing sweep; never while RST
    always_ff @(negedge CLK) begin
        if (!RST) begin
            if (state_q == StXfer && we_q) begin
                for (int i = 0; i < NumBytes; i++) begin
                    if (BE[i]) begin
                        ram[cur_addr][8*i +: 8] <= Mem_Bus[8*i +: 8];
                    end
                end
            end
`ifdef MEM_INIT_CLEAR_EN
            else if (state_q == StInit) begin
                ram[init_addr] <= '0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_burst_memory.sv
// Directed testbench for burst_memory (DATA_W=32, ADDR_W=7, WAIT_STATES=1).
// The bus net is pulled up, so an undriven bus reads as all ones.
module tb_burst_memory;

`ifdef MEM_INIT_CLEAR_EN
    localparam bit InitClear = 1'b1;
`else
    localparam bit InitClear = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        cs;
    logic        we;
    logic [6:0]  addr;
    logic [2:0]  len;
    logic [3:0]  be;
    tri1  [31:0] mem_bus;
    logic [31:0] bus_drv;
    logic        bus_en;
    logic        ready;
    logic        busy;

    int checks = 0;
    int errors = 0;

    logic [31:0] wdata [8];
    logic [31:0] rdata [8];
    logic [31:0] exp20 [4];
    int          rcount;
    int          first_lat;

    assign mem_bus = bus_en ? bus_drv : 32'hzzzz_zzzz;

    burst_memory #(
        .DATA_W      (32),
        .ADDR_W      (7),
        .WAIT_STATES (1)
    ) dut (
        .CLK     (clk),
        .RST     (rst),
        .CS      (cs),
        .WE      (we),
        .ADDR    (addr),
        .LEN     (len),
        .BE      (be),
        .Mem_Bus (mem_bus),
        .READY   (ready),
        .BUSY    (busy)
    );

    always #5 clk = ~clk;

    task automatic wait_idle();
        int cyc = 0;
        while (busy && cyc < 400) begin
            @(posedge clk);
            cyc++;
        end
        if (busy) begin
            checks++;
            errors++;
            $display("FAIL wait_idle timeout: busy=%b required 0", busy);
        end
    endtask

    task automatic do_write(input logic [6:0] a, input logic [2:0] l, input logic [3:0] b);
        int beat = 0;
        int cyc  = 1;
        @(posedge clk);
        cs = 1'b1; we = 1'b1; addr = a; len = l; be = b;
        @(posedge clk);
        cs = 1'b0;
        while (beat <= int'(l) && cyc < 50) begin
            if (ready) begin
                bus_en  = 1'b1;
                bus_drv = wdata[beat];
                beat++;
            end
            @(posedge clk);
            cyc++;
        end
        bus_en = 1'b0;
        if (beat <= int'(l)) begin
            checks++;
            errors++;
            $display("FAIL write timeout: beats %0d required %0d", beat, int'(l) + 1);
        end
    endtask

    task automatic do_read(input logic [6:0] a, input logic [2:0] l);
        int beat = 0;
        int cyc  = 1;
        first_lat = 0;
        @(posedge clk);
        cs = 1'b1; we = 1'b0; addr = a; len = l;
        @(posedge clk);
        cs = 1'b0;
        while (beat <= int'(l) && cyc < 50) begin
            if (ready) begin
                if (beat == 0) first_lat = cyc;
                rdata[beat] = mem_bus;
                beat++;
            end
            @(posedge clk);
            cyc++;
        end
        rcount = beat;
        if (beat <= int'(l)) begin
            checks++;
            errors++;
            $display("FAIL read timeout: beats %0d required %0d", beat, int'(l) + 1);
        end
    endtask

    task automatic test_reset();
        cs = 1'b0; we = 1'b0; addr = '0; len = '0; be = '0; bus_en = 1'b0; bus_drv = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (ready !== 1'b0) begin
            errors++; $display("FAIL reset_ready: got %b required 0", ready);
        end
        checks++;
        if (busy !== InitClear) begin
            errors++; $display("FAIL reset_busy: got %b required %b", busy, InitClear);
        end
        checks++;
        if (mem_bus !== 32'hFFFF_FFFF) begin
            errors++; $display("FAIL reset_bus_z: got %h required released bus", mem_bus);
        end
        wait_idle();
    endtask

    task automatic test_single();
        wdata[0] = 32'hDEAD_BEEF;
        do_write(7'd5, 3'd0, 4'hF);
        do_read(7'd5, 3'd0);
        checks++;
        if (first_lat != 2) begin
            errors++; $display("FAIL single_latency: got %0d required 2", first_lat);
        end
        checks++;
        if (rcount != 1) begin
            errors++; $display("FAIL single_beats: got %0d required 1", rcount);
        end
        checks++;
        if (rdata[0] !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL single_data: got %h required deadbeef", rdata[0]);
        end
        checks++;
        if (ready !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL single_end: ready=%b busy=%b required 0 0", ready, busy);
        end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 4; i++) wdata[i] = 32'(i + 1);
        do_write(7'd126, 3'd3, 4'hF);
        do_read(7'd126, 3'd3);
        checks++;
        if (rcount != 4) begin
            errors++; $display("FAIL wrap_beats: got %0d required 4", rcount);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rdata[i] !== 32'(i + 1)) begin
                errors++; $display("FAIL wrap_beat%0d: got %h required %h", i, rdata[i], i + 1);
            end
        end
    endtask

    task automatic test_byte_enable();
        wdata[0] = 32'hFFFF_FFFF;
        do_write(7'd10, 3'd0, 4'hF);
        wdata[0] = 32'h0000_0000;
        do_write(7'd10, 3'd0, 4'b0101);
        do_read(7'd10, 3'd0);
        checks++;
        if (rdata[0] !== 32'hFF00_FF00) begin
            errors++; $display("FAIL byte_enable: got %h required ff00ff00", rdata[0]);
        end
    endtask

    task automatic test_reset_abort();
        int beat = 0;
        int cyc  = 1;
        for (int i = 0; i < 4; i++) wdata[i] = 32'hA0A0_0000 + 32'(i);
        do_write(7'd20, 3'd3, 4'hF);
        for (int i = 0; i < 4; i++) wdata[i] = 32'hB0B0_0000 + 32'(i);
        @(posedge clk);
        cs = 1'b1; we = 1'b1; addr = 7'd20; len = 3'd3; be = 4'hF;
        @(posedge clk);
        cs = 1'b0;
        while (beat < 2 && cyc < 50) begin
            if (ready) begin
                bus_en  = 1'b1;
                bus_drv = wdata[beat];
                beat++;
            end
            @(posedge clk);
            cyc++;
        end
        // Third beat is on the bus now; reset lands on its completing edge
        bus_drv = wdata[2];
        rst     = 1'b1;
        @(posedge clk);
        rst    = 1'b0;
        bus_en = 1'b0;
        #1;
        checks++;
        if (busy !== InitClear) begin
            errors++; $display("FAIL abort_busy: got %b required %b", busy, InitClear);
        end
        checks++;
        if (ready !== 1'b0) begin
            errors++; $display("FAIL abort_ready: got %b required 0", ready);
        end
        checks++;
        if (mem_bus !== 32'hFFFF_FFFF) begin
            errors++; $display("FAIL abort_bus_z: got %h required released bus", mem_bus);
        end
        wait_idle();
        exp20[0] = InitClear ? 32'h0 : 32'hB0B0_0000;
        exp20[1] = InitClear ? 32'h0 : 32'hB0B0_0001;
        exp20[2] = InitClear ? 32'h0 : 32'hA0A0_0002;
        exp20[3] = InitClear ? 32'h0 : 32'hA0A0_0003;
        do_read(7'd20, 3'd3);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rdata[i] !== exp20[i]) begin
                errors++; $display("FAIL abort_word%0d: got %h required %h", i, rdata[i], exp20[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0]  rdy_seen;
        logic [7:0]  bsy_seen;
        logic [31:0] dat [8];
        @(posedge clk);
        cs = 1'b1; we = 1'b0; addr = 7'd20; len = 3'd1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            rdy_seen[i] = ready;
            bsy_seen[i] = busy;
            dat[i]      = mem_bus;
            if (i == 0) begin
                addr = 7'd99; len = 3'd7; we = 1'b1;
            end
            if (i == 2) begin
                addr = 7'd20; len = 3'd1; we = 1'b0;
            end
            if (i == 7) cs = 1'b0;
        end
        checks++;
        if (rdy_seen !== 8'b0110_0110) begin
            errors++; $display("FAIL b2b_ready: got %b required 01100110", rdy_seen);
        end
        checks++;
        if (bsy_seen !== 8'b0111_0111) begin
            errors++; $display("FAIL b2b_busy: got %b required 01110111", bsy_seen);
        end
        checks++;
        if (dat[1] !== exp20[0] || dat[2] !== exp20[1]) begin
            errors++; $display("FAIL b2b_burst1: got %h %h required %h %h",
                               dat[1], dat[2], exp20[0], exp20[1]);
        end
        checks++;
        if (dat[5] !== exp20[0] || dat[6] !== exp20[1]) begin
            errors++; $display("FAIL b2b_burst2: got %h %h required %h %h",
                               dat[5], dat[6], exp20[0], exp20[1]);
        end
        wait_idle();
    endtask

`ifdef MEM_INIT_CLEAR_EN
    task automatic test_init();
        int cnt = 0;
        @(posedge clk);
        rst = 1'b1;
        @(posedge clk);
        rst = 1'b0;
        while (busy && cnt < 300) begin
            cnt++;
            @(posedge clk);
        end
        checks++;
        if (cnt != 128) begin
            errors++; $display("FAIL init_busy_cycles: got %0d required 128", cnt);
        end
        do_read(7'd124, 3'd7);
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (rdata[i] !== 32'h0) begin
                errors++; $display("FAIL init_word%0d: got %h required 0", i, rdata[i]);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_wrap();
        test_byte_enable();
        test_reset_abort();
        test_back_to_back();
`ifdef MEM_INIT_CLEAR_EN
        test_init();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
